subtract_32_bit: RTL and testbench

- 32-bit two's-complement subtractor for the MIPS datapath ALU: computes a − b as a + ~b + 1 through a 32-stage full-adder carry chain.
- Registered result, carry-out (no-borrow flag), signed overflow and zero flags.
- One clock, single-cycle latency; feeds ALU result mux and branch-compare logic.

---
 rtl/subtract_32_bit_if.sv | 16 +
 rtl/subtract_32_bit.sv | 42 ++++
 tb/tb_subtract_32_bit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/subtract_32_bit_if.sv
// subtract_32_bit_if: operand/result bundle for the 32-bit subtractor
//   a, b     : minuend and subtrahend (driven by master)
//   sum      : registered a - b
//   cout     : registered carry-out, 1 = no borrow
//   overflow : registered signed overflow
//   zero     : registered all-zero difference flag
interface subtract_32_bit_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;
   modport master (output a, b, input sum, cout, overflow, zero);
   modport slave  (input a, b, output sum, cout, overflow, zero);
endinterface

// File: rtl/subtract_32_bit.sv
// subtract_32_bit: registered a - b via a + ~b + 1 ripple chain with carry, overflow and zero flags
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all outputs
//   bus   : slave side of subtract_32_bit_if (a, b in; sum, cout, overflow, zero out)
module subtract_32_bit #(parameter int WIDTH = 32) (
   input logic               clk,
   input logic               rst_n,
   subtract_32_bit_if.slave  bus
);
   logic [WIDTH-1:0] w_nb;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH:0]   w_c;
   logic             w_ov;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ov;
   logic             r_zero;
   assign w_nb   = ~bus.b;
   assign w_c[0] = 1'b1;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign w_s[i]   = bus.a[i] ^ w_nb[i] ^ w_c[i];
      assign w_c[i+1] = (bus.a[i] & w_nb[i]) | (bus.a[i] & w_c[i]) | (w_nb[i] & w_c[i]);
   end
   // signed overflow only when operand signs differ and the result sign leaves a's sign
   assign w_ov = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_s[WIDTH-1] != bus.a[WIDTH-1]);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ov   <= 1'b0;
         r_zero <= 1'b0;
      end else begin
         r_sum  <= w_s;
         r_cout <= w_c[WIDTH];
         r_ov   <= w_ov;
         r_zero <= ~|w_s;
      end
   assign bus.sum      = r_sum;
   assign bus.cout     = r_cout;
   assign bus.overflow = r_ov;
   assign bus.zero     = r_zero;
endmodule

// File: tb/tb_subtract_32_bit.sv
// tb_subtract_32_bit: scoreboard bench for subtract_32_bit against an arithmetic reference model
module tb_subtract_32_bit;
   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ov;
      logic        zero;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   subtract_32_bit_if bus ();
   subtract_32_bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask
   task automatic chk_rst(input string nm);
      chk({nm, "_sum"}, bus.sum, 32'h0);
      chk({nm, "_cout"}, {31'b0, bus.cout}, 32'h0);
      chk({nm, "_ov"}, {31'b0, bus.overflow}, 32'h0);
      chk({nm, "_zero"}, {31'b0, bus.zero}, 32'h0);
   endtask
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint d;
      d      = longint'($signed(x)) - longint'($signed(y));
      e.sum  = x - y;
      e.cout = (x >= y);
      e.ov   = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      e.zero = (x == y);
      return e;
   endfunction
   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      bus.a = x;
      bus.b = y;
      q.push_back(model(x, y));
   endtask
   // monitor: every edge captured with reset released retires one scoreboard entry
   initial forever begin
      @(posedge clk);
      if (rst_n) begin
         #1;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", bus.sum, e.sum);
            chk("cout", {31'b0, bus.cout}, {31'b0, e.cout});
            chk("overflow", {31'b0, bus.overflow}, {31'b0, e.ov});
            chk("zero", {31'b0, bus.zero}, {31'b0, e.zero});
         end
      end
   end
   initial begin
      logic [31:0] va [8];
      logic [31:0] vb [8];
      va = '{32'hFFFFFFF9, 32'd32, 32'd128, 32'd6, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
      vb = '{32'd6,        32'd16, 32'd64,  32'd7, 32'd0, 32'd1,        32'hFFFFFFFF, 32'h12345678};
      bus.a = 32'd7;
      bus.b = 32'd6;
      #1 chk_rst("reset_t0");
      repeat (3) begin
         @(negedge clk);
         chk_rst("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd7, 32'd6);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         issue(va[i], vb[i]);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         issue($urandom, $urandom);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_rst("async_reset");
      @(negedge clk);
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
      chk_rst("async_hold");
      rst_n = 1'b1;
      issue(32'hDEADBEEF, 32'h0BADF00D);
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 7))
            0: begin
               logic [31:0] t;
               t = $urandom;
               issue(t, t);
            end
            1: issue({1'b1, 31'($urandom_range(0, 3))}, 32'($urandom_range(0, 3)));
            2: issue({1'b0, ~31'($urandom_range(0, 3))}, ~32'($urandom_range(0, 3)));
            default: issue($urandom, $urandom);
         endcase
      end
      @(negedge clk);
      bus.a = 32'd0;
      bus.b = 32'd0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
